multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit beside the execute stage of the five-stage pipeline. Execute pulses a start when an `mul` (ALU_op 00110) or `div` (ALU_op 00111) instruction arrives, stalls fetch/decode/execute while `data_busy` is high, and forwards `data_result` to the execute/memory latch on the cycle `data_resultRDY` is high. A product/quotient overflow or divide-by-zero raises `data_exception` with the result, for rstatus handling downstream.

---
 rtl/processor_pkg.sv | 23 ++
 rtl/multdiv_core.sv | 63 ++++++
 rtl/multdiv_unit.sv | 130 +++++++++++++
 tb/tb_multdiv_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared processor definitions: ALU op codes, mul/div iteration count,
// multdiv FSM state encoding and rstatus codes for mul/div exceptions.
package processor_pkg;

    // ALU op codes that dispatch to the multiply/divide unit
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // One result bit per iteration
    localparam int MD_ITER = 32;

    // multdiv_unit FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // rstatus values written back when the unit flags an exception
    localparam logic [31:0] RSTATUS_MUL_OVF  = 32'd1;
    localparam logic [31:0] RSTATUS_DIV_ZERO = 32'd2;
    localparam logic [31:0] RSTATUS_DIV_OVF  = 32'd3;

endpackage

// File: rtl/multdiv_core.sv
// Iterative magnitude datapath: MSB-first shift-add multiply and restoring
// divide, one bit per enabled step. Operates on unsigned magnitudes only;
// sign handling lives in the top level.
module multdiv_core
    import processor_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mode_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;

    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;

    // Next accumulator value for one multiply or divide step
    always_comb begin
        // Multiply: acc = 2*acc + (current multiplier MSB ? multiplicand : 0)
        mul_next = {acc[2*WIDTH-2:0], 1'b0}
                 + (b_reg[WIDTH-1] ? {{WIDTH{1'b0}}, a_reg} : {(2*WIDTH){1'b0}});
        // Divide: remainder in acc upper half, quotient built in lower half
        shifted  = {acc[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
        trial    = shifted - {1'b0, b_reg};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        div_next = {rem_next, acc[WIDTH-2:0], q_bit};
        acc_next = mode_div ? div_next : mul_next;
    end

    // Operand/accumulator registers: load on accept, advance on each step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else if (load) begin
            a_reg <= a_mag;
            b_reg <= b_mag;
            acc   <= '0;
        end else if (step) begin
            acc <= acc_next;
            if (mode_div)
                a_reg <= {a_reg[WIDTH-2:0], 1'b0};
            else
                b_reg <= {b_reg[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit beside the execute stage. Holds the
// FSM, iteration counter, sign fixup and exception detection; the shift/
// add-subtract datapath lives in multdiv_core. All outputs are registered.
module multdiv_unit
    import processor_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               neg_res;
    logic               div_zero;
    logic               div_ovf;

    logic               can_start;
    logic               accept;
    logic               running;
    logic               last;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] signed_acc;
    logic [WIDTH-1:0]   res_next;
    logic               exc_next;

    // Two's-complement magnitude of a signed operand (MIN maps to 2^(W-1))
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // Apply the result sign to the full-width magnitude
    function automatic logic [2*WIDTH-1:0] sign_fix(input logic neg,
                                                    input logic [2*WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign can_start = (state == ST_IDLE) || (state == ST_DONE);
    assign accept    = can_start && (ctrl_MULT || ctrl_DIV);
    assign running   = (state == ST_MUL) || (state == ST_DIV);
    assign last      = running && (count == LAST);

    multdiv_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .step     (running),
        .mode_div (state == ST_DIV),
        .a_mag    (abs_mag(data_operandA)),
        .b_mag    (abs_mag(data_operandB)),
        .acc_next (acc_next)
    );

    // Final result and exception from the last step's accumulator
    always_comb begin
        signed_acc = sign_fix(neg_res, acc_next);
        res_next   = signed_acc[WIDTH-1:0];
        exc_next   = 1'b0;
        if (state == ST_DIV) begin
            if (div_zero) begin
                res_next = '0;
                exc_next = 1'b1;
            end else if (div_ovf) begin
                exc_next = 1'b1;
            end
        end else begin
            // Product overflows when the upper half is not a sign extension
            exc_next = (signed_acc[2*WIDTH-1:WIDTH] != {WIDTH{signed_acc[WIDTH-1]}});
        end
    end

    // Control FSM, iteration counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            count          <= '0;
            neg_res        <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            data_busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    data_resultRDY <= 1'b0;
                    if (accept) begin
                        state     <= ctrl_MULT ? ST_MUL : ST_DIV;
                        count     <= '0;
                        data_busy <= 1'b1;
                        neg_res   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_zero  <= (data_operandB == '0);
                        div_ovf   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                                  && (data_operandB == {WIDTH{1'b1}});
                    end else begin
                        state     <= ST_IDLE;
                        data_busy <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    count <= count + 1'b1;
                    if (last) begin
                        state          <= ST_DONE;
                        data_busy      <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= res_next;
                        data_exception <= exc_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: expected results are queued when an
// operation is started and compared by a monitor when data_resultRDY pulses.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    always #5 clock = ~clock;

    // Cycle count, advanced on every active edge
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: compare every RDY pulse against the oldest expectation
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rdy: RDY at cycle %0d, no operation outstanding", cyc);
            end else begin
                mon_e = sb.pop_front();
                total++;
                if (data_result !== mon_e.res) begin
                    bad++;
                    $display("FAIL result: got %h expected %h", data_result, mon_e.res);
                end
                total++;
                if (data_exception !== mon_e.exc) begin
                    bad++;
                    $display("FAIL exception: got %b expected %b (result %h)", data_exception, mon_e.exc, mon_e.res);
                end
                total++;
                if (cyc !== mon_e.due) begin
                    bad++;
                    $display("FAIL latency: RDY at cycle %0d expected %0d", cyc, mon_e.due);
                end
                total++;
                if (data_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_in_rdy: got %b expected 0", data_busy);
                end
            end
        end
    end

    // Reference model built from native signed arithmetic
    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    // Drive a one-cycle start; call away from the rising edge
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ee, input bit track);
        exp_t e;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        if (track) begin
            e.res = er;
            e.exc = ee;
            e.due = cyc + 32;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        total++; if (data_result !== 32'd0)  begin bad++; $display("FAIL reset_result: got %h expected 0", data_result); end
        total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL reset_exception: got %b expected 0", data_exception); end
        total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
        total++; if (data_busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b expected 0", data_busy); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mul();
        start_op(1, 0, 32'd7, 32'd2, 32'd14, 1'b0, 1);
        total++; if (data_busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b expected 1", data_busy); end
        repeat (31) @(negedge clock);
        total++; if (data_busy !== 1'b1) begin bad++; $display("FAIL busy_last_iter: got %b expected 1", data_busy); end
        wait_drain("mul_7x2");
        start_op(1, 0, -32'sd7, 32'd3, 32'hFFFF_FFEB, 1'b0, 1);
        wait_drain("mul_neg7x3");
        start_op(1, 0, 32'd65536, 32'd65536, 32'd0, 1'b1, 1);
        wait_drain("mul_ovf");
    endtask

    task automatic test_div();
        start_op(0, 1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 1'b0, 1);
        wait_drain("div_100_neg7");
        start_op(0, 1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0, 1);
        wait_drain("div_neg100_7");
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1);
        wait_drain("div_ovf");
        start_op(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, 1);
        wait_drain("div_zero");
    endtask

    task automatic test_ignore_mid();
        start_op(1, 0, 32'd7, 32'd2, 32'd14, 1'b0, 1);
        repeat (5) @(negedge clock);
        start_op(0, 1, 32'd100, 32'd5, 32'd20, 1'b0, 0);
        wait_drain("ignore_mid");
        total++; if (data_busy !== 1'b0) begin bad++; $display("FAIL ignored_start_busy: got %b expected 0", data_busy); end
    endtask

    task automatic test_both();
        start_op(1, 1, 32'd6, 32'd3, 32'd18, 1'b0, 1);
        wait_drain("mult_wins");
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        start_op(1, 0, 32'd7, 32'd2, 32'd14, 1'b0, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL b2b_first_rdy: RDY seen %b expected 1", seen);
        end
        start_op(0, 1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 1'b0, 1);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        int rdy_cnt = 0;
        start_op(0, 1, 32'd1000, 32'd3, 32'd333, 1'b0, 0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (data_busy !== 1'b0)      begin bad++; $display("FAIL abort_busy: got %b expected 0", data_busy); end
        total++; if (data_result !== 32'd0)   begin bad++; $display("FAIL abort_result: got %h expected 0", data_result); end
        total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL abort_rdy: got %b expected 0", data_resultRDY); end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL abort_no_rdy: got %0d pulses expected 0", rdy_cnt); end
        start_op(1, 0, 32'd7, 32'd2, 32'd14, 1'b0, 1);
        wait_drain("after_abort");
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic        e;
        bit          m;
        for (int i = 0; i < 8; i++) begin
            m = (i % 2) == 0;
            a = $urandom;
            b = (i < 4) ? $urandom_range(0, 70000) : $urandom;
            if (i == 5) b = 32'd0;
            if (b[0]) b = -b;
            model(m, a, b, r, e);
            start_op(m, !m, a, b, r, e, 1);
            wait_drain("random");
        end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_ignore_mid();
        test_both();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
